// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Operand-issue stage sitting directly in front of the ALU. It decodes an RV32
// instruction, reads rs1/rs2 from an internal register file (with same-cycle
// writeback forwarding), selects rs2 or an immediate as operand2, and presents
// a registered bundle to the ALU under a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   instruction handshake (in_ready is combinational)
//   in_instr              RV32 instruction word
//   wb_en/wb_addr/wb_data register-file writeback (writes to x0 ignored)
//   out_valid / out_ready issue-bundle handshake toward the ALU
//   operand1, operand2    rs1 value, rs2 value or immediate
//   funct3_alu, Type_alu  ALU operation select (Type_alu = SUB/SRA variant)
//   out_rd, out_rd_we     destination register and its write enable
//   out_illegal           opcode is neither R-type nor I-type ALU
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [2:0]        funct3_alu,
    output logic              Type_alu,
    output logic [AW-1:0]     out_rd,
    output logic              out_rd_we,
    output logic              out_illegal
);

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;

    logic [DATA_W-1:0] rf [NREGS];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    logic [DATA_W-1:0] dec_op1;
    logic [DATA_W-1:0] dec_op2;
    logic              dec_type;
    logic              dec_illegal;
    logic              dec_rd_we;

    logic              accept;
    logic              wb_write;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[15 +: AW];
    assign rs2    = in_instr[20 +: AW];
    assign rd     = in_instr[7 +: AW];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_write = wb_en && (wb_addr != '0);

    // Register read with bypass of a writeback landing on the same edge.
    always_comb begin
        rs1_val = rf[rs1];
        if (rs1 == '0)
            rs1_val = '0;
        else if (wb_write && (wb_addr == rs1))
            rs1_val = wb_data;
    end

    always_comb begin
        rs2_val = rf[rs2];
        if (rs2 == '0)
            rs2_val = '0;
        else if (wb_write && (wb_addr == rs2))
            rs2_val = wb_data;
    end

    always_comb begin
        dec_op1     = '0;
        dec_op2     = '0;
        dec_type    = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R_TYPE: begin
                dec_op1  = rs1_val;
                dec_op2  = rs2_val;
                dec_type = in_instr[30];
            end
            OP_I_ALU: begin
                dec_op1 = rs1_val;
                // Shifts take a zero-extended 5-bit shamt; instr[30] picks SRAI.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_op2  = {{(DATA_W-5){1'b0}}, in_instr[24:20]};
                    dec_type = in_instr[30];
                end else begin
                    dec_op2  = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_rd_we = !dec_illegal && (rd != '0);
    end

    // Writeback is independent of the issue handshake, so it proceeds during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_write) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Output bundle: loaded on accept (also replaces a bundle leaving on the
    // same edge), otherwise held; valid drops only when the bundle leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            operand1    <= '0;
            operand2    <= '0;
            funct3_alu  <= '0;
            Type_alu    <= 1'b0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            operand1    <= dec_op1;
            operand2    <= dec_op2;
            funct3_alu  <= funct3;
            Type_alu    <= dec_type;
            out_rd      <= rd;
            out_rd_we   <= dec_rd_we;
            out_illegal <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  f3;
        logic        ty;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  funct3_alu;
    logic        Type_alu;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    bundle_t     exp_q[$];
    logic [31:0] model_rf [32];

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand1(operand1), .operand2(operand2),
        .funct3_alu(funct3_alu), .Type_alu(Type_alu),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: architectural register state seen by an instruction accepted
    // this cycle, including a writeback that lands on the same edge.
    function automatic logic [31:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return model_rf[idx];
    endfunction

    function automatic bundle_t ref_issue(input logic [31:0] ins);
        bundle_t b;
        logic [11:0] imm;
        imm   = ins[31:20];
        b     = '0;
        b.f3  = ins[14:12];
        b.rd  = ins[11:7];
        if (ins[6:0] == 7'b0110011) begin
            b.op1 = read_reg(ins[19:15]);
            b.op2 = read_reg(ins[24:20]);
            b.ty  = ins[30];
        end else if (ins[6:0] == 7'b0010011) begin
            b.op1 = read_reg(ins[19:15]);
            if (b.f3 == 3'd1 || b.f3 == 3'd5) begin
                b.op2 = 32'(ins[24:20]);
                b.ty  = ins[30];
            end else begin
                b.op2 = 32'($signed(imm));
            end
        end else begin
            b.ill = 1'b1;
        end
        b.we = !b.ill && (b.rd != 5'd0);
        return b;
    endfunction

    // Model: records accepted instructions and tracks register writes.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(ref_issue(in_instr));
            if (wb_en && wb_addr != 5'd0) model_rf[wb_addr] = wb_data;
        end
    end

    // Monitor: checks handshake, stall stability and every transferred bundle.
    bundle_t snap;
    bit      prev_stall = 0;
    always @(negedge clk) begin
        bundle_t cur;
        bundle_t e;
        cur = {operand1, operand2, funct3_alu, Type_alu, out_rd, out_rd_we, out_illegal};
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'((exp_q.size() == 0) || out_ready));
            if (prev_stall)
                chk("stall_hold", 64'(cur[76:64]) ^ {cur[63:0]}, 64'(snap[76:64]) ^ {snap[63:0]});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bundle", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("operand1", 64'(cur.op1), 64'(e.op1));
                    chk("operand2", 64'(cur.op2), 64'(e.op2));
                    chk("ctrl", 64'({cur.f3, cur.ty, cur.rd, cur.we, cur.ill}),
                                64'({e.f3, e.ty, e.rd, e.we, e.ill}));
                end
            end
            prev_stall = out_valid && !out_ready;
            snap = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, output int edges);
        bit acc;
        acc = 0;
        edges = 0;
        in_valid = 1'b1;
        in_instr = ins;
        while (!acc && edges < 40) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            edges++;
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [2:0] f3, input logic ty, input logic [4:0] rd,
                           input logic we, input logic ill);
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_op1"}, 64'(operand1), 64'(o1));
        chk({name, "_op2"}, 64'(operand2), 64'(o2));
        chk({name, "_ctrl"}, 64'({funct3_alu, Type_alu, out_rd, out_rd_we, out_illegal}),
                             64'({f3, ty, rd, we, ill}));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        sel = $urandom_range(0, 9);
        r = $urandom;
        r[24:20] = {2'b00, 3'($urandom_range(0, 7))};
        r[19:15] = {2'b00, 3'($urandom_range(0, 7))};
        if (sel < 4) begin
            r[31:25] = {1'b0, r[30], 5'b0};
            r[6:0]   = 7'b0110011;
        end else if (sel < 8) begin
            r[6:0] = 7'b0010011;
        end else if (r[6:0] == 7'b0110011 || r[6:0] == 7'b0010011) begin
            r[2] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        int n;
        rst_n = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outs", 64'({operand1, operand2}), 64'(0));
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));
        tick();

        // 1. add x3,x1,x2
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        send(32'h002081B3, n);
        chk_out("add", 32'd5, 32'd3, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);

        // 2. sub, addi -1
        send(32'h402081B3, n);
        chk_out("sub", 32'd5, 32'd3, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0);
        send(32'hFFF08213, n);
        chk_out("addi", 32'd5, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0);

        // 3. srai / slli
        send(32'h4030D293, n);
        chk_out("srai", 32'd5, 32'd3, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0);
        send(32'h01F09293, n);
        chk_out("slli", 32'd5, 32'd31, 3'b001, 1'b0, 5'd5, 1'b1, 1'b0);

        // 4. stall for 4 cycles then back-to-back
        send(32'h002081B3, n);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h402081B3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk_out("stall", 32'd5, 32'd3, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        send(32'h402081B3, n);
        chk("b2b_edges0", 64'(n), 64'(1));
        in_valid = 1'b1;
        send(32'hFFF08213, n);
        chk("b2b_edges1", 64'(n), 64'(1));
        chk_out("b2b_addi", 32'd5, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0);
        send(32'h4030D293, n);
        chk("b2b_edges2", 64'(n), 64'(1));
        chk_out("b2b_srai", 32'd5, 32'd3, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0);

        // 5. forwarding and x0
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD;
        send(32'h001081B3, n);
        wb_en = 1'b0;
        chk_out("fwd", 32'hDEAD, 32'hDEAD, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        wb_write(5'd0, 32'h1234);
        send(32'h000001B3, n);
        chk_out("x0", 32'd0, 32'd0, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
        send(32'h002081B3, n);
        chk_out("after_fwd", 32'hDEAD, 32'd3, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);

        // 6. illegal opcode, then reset while stalled
        send(32'h00008203, n);
        chk_out("illegal", 32'd0, 32'd0, 3'b000, 1'b0, 5'd4, 1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(32'h002081B3, n);
        chk_out("rf_cleared", 32'd0, 32'd0, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            tick();
        end
        in_valid = 1'b0;
        wb_en = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
